// File: rtl/alu.sv
// 8-bit combinational ALU for the execute stage; result is valid in the same cycle.
// RESET forces Out to zero asynchronously; CLK is present for integration only.
module alu (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IN_A,
  input  logic [7:0] IN_B,
  input  logic [3:0] ALU_Op_Code,
  output logic [7:0] Out
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_SHL  = 4'h3,
    OP_SHR  = 4'h4,
    OP_INCA = 4'h5,
    OP_INCB = 4'h6,
    OP_DECA = 4'h7,
    OP_DECB = 4'h8,
    OP_EQ   = 4'h9,
    OP_GT   = 4'hA,
    OP_LT   = 4'hB
  } op_t;

  logic [7:0] result;
  logic       unused_clk;

  // No clocked state in this revision; the clock is kept only so the port list matches the datapath.
  assign unused_clk = CLK;

  // Each arm reads only the operands it needs, so X on an unused operand cannot leak into Out.
  always_comb begin
    result = 8'h00;
    case (ALU_Op_Code)
      OP_ADD:  result = IN_A + IN_B;
      OP_SUB:  result = IN_A - IN_B;
      OP_MUL:  result = IN_A * IN_B;
      OP_SHL:  result = {IN_A[6:0], 1'b0};
      OP_SHR:  result = {1'b0, IN_A[7:1]};
      OP_INCA: result = IN_A + 8'd1;
      OP_INCB: result = IN_B + 8'd1;
      OP_DECA: result = IN_A - 8'd1;
      OP_DECB: result = IN_B - 8'd1;
      OP_EQ:   result = {7'b0, IN_A == IN_B};
      OP_GT:   result = {7'b0, IN_A > IN_B};
      OP_LT:   result = {7'b0, IN_A < IN_B};
      default: result = 8'h00;
    endcase
  end

  assign Out = RESET ? 8'h00 : result;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/clock corner sequences,
// and random vectors against an arithmetic reference model.
module tb_alu;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IN_A;
  logic [7:0] IN_B;
  logic [3:0] ALU_Op_Code;
  logic [7:0] Out;

  int vectors = 0;
  int miscompares = 0;

  alu dut (
    .CLK(CLK),
    .RESET(RESET),
    .IN_A(IN_A),
    .IN_B(IN_B),
    .ALU_Op_Code(ALU_Op_Code),
    .Out(Out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference computed with plain integer arithmetic, reduced modulo 256.
  function automatic logic [7:0] model(input int op, input int a, input int b);
    int r;
    case (op)
      0:  r = (a + b) % 256;
      1:  r = (a - b + 256) % 256;
      2:  r = (a * b) % 256;
      3:  r = (a * 2) % 256;
      4:  r = a / 2;
      5:  r = (a + 1) % 256;
      6:  r = (b + 1) % 256;
      7:  r = (a + 255) % 256;
      8:  r = (b + 255) % 256;
      9:  r = (a == b) ? 1 : 0;
      10: r = (a > b) ? 1 : 0;
      11: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    vectors++;
    if (Out !== exp) begin
      miscompares++;
      $display("FAIL %s: Out=%h expected=%h (op=%h A=%h B=%h RESET=%b)",
               name, Out, exp, ALU_Op_Code, IN_A, IN_B, RESET);
    end
  endtask

  // Inputs change just after a falling edge and are sampled 1 ns later, well away from posedge.
  task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge CLK);
    ALU_Op_Code = op;
    IN_A = a;
    IN_B = b;
    #1;
  endtask

  initial begin
    logic [7:0] held;
    logic [7:0] ra, rb;
    logic [3:0] rop;
    int xops[4];

    tbl.push_back('{4'h0, 8'h05, 8'h03, 8'h08});
    tbl.push_back('{4'h1, 8'h05, 8'h03, 8'h02});
    tbl.push_back('{4'h2, 8'h02, 8'h03, 8'h06});
    tbl.push_back('{4'h0, 8'hFF, 8'h01, 8'h00});
    tbl.push_back('{4'h1, 8'h03, 8'h05, 8'hFE});
    tbl.push_back('{4'h2, 8'h10, 8'h10, 8'h00});
    tbl.push_back('{4'h3, 8'h01, 8'h77, 8'h02});
    tbl.push_back('{4'h3, 8'h81, 8'h00, 8'h02});
    tbl.push_back('{4'h4, 8'h02, 8'hFF, 8'h01});
    tbl.push_back('{4'h5, 8'h05, 8'h00, 8'h06});
    tbl.push_back('{4'h5, 8'hFF, 8'h00, 8'h00});
    tbl.push_back('{4'h6, 8'h00, 8'h05, 8'h06});
    tbl.push_back('{4'h7, 8'h05, 8'h00, 8'h04});
    tbl.push_back('{4'h7, 8'h00, 8'h00, 8'hFF});
    tbl.push_back('{4'h8, 8'h00, 8'h05, 8'h04});
    tbl.push_back('{4'h9, 8'h05, 8'h05, 8'h01});
    tbl.push_back('{4'h9, 8'h05, 8'h06, 8'h00});
    tbl.push_back('{4'hA, 8'h06, 8'h05, 8'h01});
    tbl.push_back('{4'hA, 8'h05, 8'h05, 8'h00});
    tbl.push_back('{4'hB, 8'h04, 8'h05, 8'h01});
    tbl.push_back('{4'hB, 8'hFF, 8'h01, 8'h00});
    tbl.push_back('{4'hC, 8'hAA, 8'h55, 8'h00});
    tbl.push_back('{4'hD, 8'hAA, 8'h55, 8'h00});
    tbl.push_back('{4'hE, 8'hAA, 8'h55, 8'h00});
    tbl.push_back('{4'hF, 8'hAA, 8'h55, 8'h00});

    // Reset holds Out at zero; release restores the result with no clock edge.
    RESET = 1'b1;
    apply(4'h0, 8'h05, 8'h03);
    check("reset_hold", 8'h00);
    RESET = 1'b0;
    #1;
    check("reset_release", 8'h08);

    foreach (tbl[i]) begin
      apply(tbl[i].op, tbl[i].a, tbl[i].b);
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Async reset mid-operation, between clock edges.
    apply(4'h0, 8'h05, 8'h03);
    #2;
    RESET = 1'b1;
    #1;
    check("async_assert", 8'h00);
    RESET = 1'b0;
    #1;
    check("async_release", 8'h08);

    // Reset overrides every opcode, including ones with nonzero results.
    RESET = 1'b1;
    apply(4'h7, 8'h00, 8'h00);
    check("reset_dec_wrap", 8'h00);
    apply(4'h2, 8'h0F, 8'h0F);
    check("reset_mul", 8'h00);
    RESET = 1'b0;
    #1;
    check("release_mul", 8'hE1);

    // A rising clock edge with steady inputs must leave Out unchanged.
    apply(4'h2, 8'h07, 8'h09);
    held = model(2, 7, 9);
    check("pre_edge", held);
    @(posedge CLK);
    #1;
    check("post_edge", held);

    // Unknown B must not disturb ops that ignore it.
    xops = '{3, 4, 5, 7};
    foreach (xops[i]) begin
      ra = 8'($urandom_range(0, 255));
      apply(4'(xops[i]), ra, 8'hxx);
      check($sformatf("xb_op%0d", xops[i]), model(xops[i], int'(ra), 0));
    end

    for (int n = 0; n < 400; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom_range(0, 255));
      rb  = (n % 8 == 0) ? ra : 8'($urandom_range(0, 255));
      apply(rop, ra, rb);
      check($sformatf("rand[%0d]", n), model(int'(rop), int'(ra), int'(rb)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
